pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed ID/EX latch: a generic pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Separates a control bundle, zeroed on bubbles, from a data bundle, which holds its value.
- Adds stall back-pressure, synchronous flush, and full throughput without a combinational ready path.

Parameters:
CTRL_W, 8, width of the control bundle (RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, ALUOp, ...)
DATA_W, 111, width of the data bundle (two read operands, immediate, funct, rd)

Ports:
clk_i  input  1  clock, rising-edge
rst_i  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous flush; empties the stage
valid_i  input  1  upstream entry valid
ready_o  output  1  stage can accept; registered
ctrl_i  input  CTRL_W  upstream control bundle
data_i  input  DATA_W  upstream data bundle
valid_o  output  1  downstream entry valid
ready_i  input  1  downstream can accept
ctrl_o  output  CTRL_W  control to next stage; all-zero when valid_o=0
data_o  output  DATA_W  data to next stage
occ_o  output  2  entries held: 0, 1 or 2

Behaviour:
- Transfer definitions:
  - Accept = valid_i & ready_o.
  - Send = valid_o & ready_i.
- Storage: main register (drives outputs) and skid register.
- FSM states:
  - EMPTY: occ 0
  - HALF: occ 1, entry in main
  - FULL: occ 2, main plus skid
- Derived outputs:
  - valid_o = (state != EMPTY).
  - ready_o = (state != FULL) & rst_i, taken from a flop; no combinational path from ready_i to ready_o.
  - ctrl_o = valid_o ? main_ctrl : 0. Bubbles never carry write enables.
- Transitions (no flush):
  - EMPTY: accept -> HALF, main<=in; else stay.
  - HALF: accept & !send -> FULL, skid<=in.
  - HALF: accept & send -> HALF, main<=in.
  - HALF: !accept & send -> EMPTY.
  - HALF: neither -> hold.
  - FULL: send -> HALF, main<=skid; else hold. No accept is possible because ready_o=0.
- Latency and ordering:
  - Latency is 1 cycle: accepted at edge N, so valid_o=1 with that payload after edge N.
  - Throughput is 1 entry/cycle while ready_i=1.
  - Ordering is strict FIFO; an entry is never duplicated or dropped except by flush.
- Flush (highest priority):
  - On a flush_i=1 edge, the state goes to EMPTY.
  - Any same-cycle accept is discarded; the upstream sees the handshake complete and the entry is lost by design.
  - A same-cycle send is still a valid transfer.
  - main_ctrl and skid_ctrl are cleared to 0; data registers are left unchanged.
- Reset (asserted at any time, including mid-transfer):
  - State EMPTY, occ_o=0, valid_o=0, ready_o=0 while rst_i=0.
  - All ctrl and data registers cleared to 0.
  - ready_o=1 in the first cycle after deassertion.
- Data hold:
  - data_o holds its last value when valid_o=0.
  - Main and skid registers load only on the transitions listed above; no spurious loads when valid_i=0.
- Boundary cases:
  - FULL with ready_i=0: stall indefinitely; outputs and occ_o stable.
  - valid_i toggling while ready_o=0 has no effect.

Optional Feature:
PIPE_STAGE_PERF_EN:
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments each cycle with valid_o & !ready_i.
  - flush_cnt_o increments each cycle with flush_i=1.
  - Both are cleared by reset and wrap 0xFFFFFFFF -> 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then stream: hold ready_i=1 and send ctrl 0x11,0x12,0x13 on consecutive cycles. Required: valid_o on each of the next 3 cycles with ctrl_o 0x11,0x12,0x13 in order, and occ_o stays 1.
- Back-pressure: ready_i=0, push A then B. Required: occ_o=2 and ready_o=0 after 2 edges. Then ready_i=1: A then B are output and ready_o returns to 1 one cycle later.
- Flush in FULL with a same-cycle send: required next cycle valid_o=0, ctrl_o=0, occ_o=0, and data_o unchanged.
- Flush with a same-cycle accept (HALF, valid_i=1): the accepted entry is never output. valid_o=0 next cycle.
- Async reset asserted mid-cycle in HALF: valid_o, ready_o, ctrl_o and data_o go to 0 immediately without a clock edge. ready_o=1 on the first edge after release.
- With PIPE_STAGE_PERF_EN: 5 cycles of valid_o=1 & ready_i=0 followed by 2 flush cycles. Required: stall_cnt_o=5 and flush_cnt_o=2.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake and 2-entry skid buffer
// Optional perf counters (stall_cnt_o, flush_cnt_o) enabled by `define PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 111
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ready;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic                w_accept;
  logic                w_send;
  logic                w_main_from_in;
  logic                w_main_from_skid;
  logic                w_skid_from_in;

  assign valid_o  = (r_state != S_EMPTY);
  assign ready_o  = r_ready;
  assign ctrl_o   = valid_o ? r_main_ctrl : '0;
  assign data_o   = r_main_data;
  assign occ_o    = r_state;
  assign w_accept = valid_i & r_ready;
  assign w_send   = valid_o & ready_i;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = S_HALF;
          w_main_from_in = 1'b1;
        end
      end
      S_HALF: begin
        if (w_accept && !w_send) begin
          w_state_nxt    = S_FULL;
          w_skid_from_in = 1'b1;
        end else if (w_accept && w_send) begin
          w_main_from_in = 1'b1;
        end else if (w_send) begin
          w_state_nxt    = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_send) begin
          w_state_nxt      = S_HALF;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush wins over everything; a same-cycle accept is dropped on purpose.
    if (flush_i) begin
      w_state_nxt      = S_EMPTY;
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_EMPTY;
      r_ready     <= 1'b0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != S_FULL);
      if (flush_i) begin
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
      end else begin
        if (w_main_from_in) begin
          r_main_ctrl <= ctrl_i;
          r_main_data <= data_i;
        end else if (w_main_from_skid) begin
          r_main_ctrl <= r_skid_ctrl;
          r_main_data <= r_skid_data;
        end
        if (w_skid_from_in) begin
          r_skid_ctrl <= ctrl_i;
          r_skid_data <= data_i;
        end
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (valid_o && !ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush_i)             r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 111;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [CW-1:0] ctrl_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [CW-1:0] ctrl_o;
  logic [DW-1:0] data_o;
  logic [1:0]    occ_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt_o;
  logic [31:0]   flush_cnt_o;
`endif

  int total = 0;
  int bad = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o),
    .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o), .occ_o(occ_o)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] mkd(input logic [7:0] c);
    return {8'hA5, 95'h0, c};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] c);
    valid_i = 1'b1;
    ctrl_i  = c;
    data_i  = mkd(c);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    step();
    step();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", ready_o); end
    total++; if (occ_o !== 2'd0) begin bad++; $display("FAIL rst_occ: got %0d want 0", occ_o); end
    total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL rst_ctrl: got %h want 00", ctrl_o); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", data_o); end
    rst_i = 1'b1;
    step();
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_stream();
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h12; seq[2] = 8'h13;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(seq[i]);
      step();
      total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid%0d: got %b want 1", i, valid_o); end
      total++; if (ctrl_o !== seq[i]) begin bad++; $display("FAIL stream_ctrl%0d: got %h want %h", i, ctrl_o, seq[i]); end
      total++; if (occ_o !== 2'd1) begin bad++; $display("FAIL stream_occ%0d: got %0d want 1", i, occ_o); end
    end
    valid_i = 1'b0;
    step();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL stream_drain_valid: got %b want 0", valid_o); end
    total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL stream_bubble_ctrl: got %h want 00", ctrl_o); end
    total++; if (data_o !== mkd(8'h13)) begin bad++; $display("FAIL stream_data_hold: got %h want %h", data_o, mkd(8'h13)); end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    push(8'h21);
    step();
    push(8'h22);
    step();
    total++; if (occ_o !== 2'd2) begin bad++; $display("FAIL bp_occ_full: got %0d want 2", occ_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_full: got %b want 0", ready_o); end
    total++; if (ctrl_o !== 8'h21) begin bad++; $display("FAIL bp_head: got %h want 21", ctrl_o); end
    push(8'h23);
    step();
    total++; if (occ_o !== 2'd2) begin bad++; $display("FAIL bp_stall_occ: got %0d want 2", occ_o); end
    total++; if (ctrl_o !== 8'h21) begin bad++; $display("FAIL bp_stall_ctrl: got %h want 21", ctrl_o); end
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    total++; if (ctrl_o !== 8'h22) begin bad++; $display("FAIL bp_second: got %h want 22", ctrl_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_back: got %b want 1", ready_o); end
    total++; if (occ_o !== 2'd1) begin bad++; $display("FAIL bp_occ_half: got %0d want 1", occ_o); end
    total++; if (data_o !== mkd(8'h22)) begin bad++; $display("FAIL bp_data: got %h want %h", data_o, mkd(8'h22)); end
    step();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", valid_o); end
  endtask

  task automatic test_flush_full();
    ready_i = 1'b0;
    push(8'h31);
    step();
    push(8'h32);
    step();
    valid_i = 1'b0;
    flush_i = 1'b1;
    ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL ff_valid: got %b want 0", valid_o); end
    total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL ff_ctrl: got %h want 00", ctrl_o); end
    total++; if (occ_o !== 2'd0) begin bad++; $display("FAIL ff_occ: got %0d want 0", occ_o); end
    total++; if (data_o !== mkd(8'h31)) begin bad++; $display("FAIL ff_data: got %h want %h", data_o, mkd(8'h31)); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL ff_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_flush_accept();
    ready_i = 1'b0;
    push(8'h41);
    step();
    push(8'h42);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL fa_valid: got %b want 0", valid_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL fa_lost%0d: got %b want 0", i, valid_o); end
    end
    total++; if (data_o !== mkd(8'h41)) begin bad++; $display("FAIL fa_data: got %h want %h", data_o, mkd(8'h41)); end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0;
    push(8'h51);
    step();
    valid_i = 1'b0;
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL ar_pre_valid: got %b want 1", valid_o); end
    #2;
    rst_i = 1'b0;
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", valid_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL ar_ready: got %b want 0", ready_o); end
    total++; if (ctrl_o !== 8'h00) begin bad++; $display("FAIL ar_ctrl: got %h want 00", ctrl_o); end
    total++; if (data_o !== '0) begin bad++; $display("FAIL ar_data: got %h want 0", data_o); end
    total++; if (occ_o !== 2'd0) begin bad++; $display("FAIL ar_occ: got %0d want 0", occ_o); end
    step();
    rst_i = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL ar_ready_pre_edge: got %b want 0", ready_o); end
    step();
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL ar_ready_post: got %b want 1", ready_o); end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    ready_i = 1'b0;
    push(8'h61);
    step();
    valid_i = 1'b0;
    repeat (5) step();
    ready_i = 1'b1;
    flush_i = 1'b1;
    repeat (2) step();
    flush_i = 1'b0;
    total++; if (stall_cnt_o !== 32'd5) begin bad++; $display("FAIL perf_stall: got %0d want 5", stall_cnt_o); end
    total++; if (flush_cnt_o !== 32'd2) begin bad++; $display("FAIL perf_flush: got %0d want 2", flush_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_accept();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
